dm_responder: RTL and testbench

DM_RESPONDER -- requirements
Module: dm_responder

---
 rtl/dm_responder.sv | 159 +++++++++++++++
 tb/tb_dm_responder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/dm_responder.sv
// Data-memory responder: accepts one load/store, waits WAIT_CYCLES, then responds.
// Optional alignment checking is enabled by defining DM_ALIGN_CHECK_EN.
module dm_responder #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned DEPTH_LOG2  = 10
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic [31:0] Addr,
    input  logic        MemWrite,
    input  logic [1:0]  MemWriteCtr,
    input  logic [2:0]  MemOutCtr,
    input  logic [31:0] WriteData,
    output logic        RespValid,
    input  logic        RespReady,
    output logic [31:0] RespData,
    output logic        RespErr
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned AW    = DEPTH_LOG2 + 2;
    localparam logic [3:0]  CNT_INIT = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

    state_e        state_q;
    logic [3:0]    cnt_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q;
    logic          we_q;
    logic [1:0]    wctr_q;
    logic [2:0]    octr_q;
    logic          ready_q, rvalid_q, rerr_q;
    logic [31:0]   rdata_q;
    logic [31:0]   mem_q [DEPTH];

    logic unused_addr_hi;
    assign unused_addr_hi = ^Addr[31:AW];

    logic accept, enter_resp;
    assign accept     = ReqValid & ready_q;
    assign enter_resp = (WAIT_CYCLES == 0) ? (state_q == S_IDLE && accept)
                                           : (state_q == S_WAIT && cnt_q == 4'd0);

    // With zero wait the access happens on the accepting edge, so use the live inputs.
    logic [AW-1:0] a_addr;
    logic [31:0]   a_wdata;
    logic          a_we;
    logic [1:0]    a_wctr;
    logic [2:0]    a_octr;
    assign a_addr  = (state_q == S_IDLE) ? Addr[AW-1:0] : addr_q;
    assign a_wdata = (state_q == S_IDLE) ? WriteData    : wdata_q;
    assign a_we    = (state_q == S_IDLE) ? MemWrite     : we_q;
    assign a_wctr  = (state_q == S_IDLE) ? MemWriteCtr  : wctr_q;
    assign a_octr  = (state_q == S_IDLE) ? MemOutCtr    : octr_q;

    logic [DEPTH_LOG2-1:0] idx;
    logic [31:0] rword, ldata, resp_data, wd;
    logic [15:0] half;
    logic [7:0]  byt;
    logic [3:0]  be;
    logic        err, mem_wr;

    assign idx   = a_addr[AW-1:2];
    assign rword = mem_q[idx];
    assign half  = a_addr[1] ? rword[31:16] : rword[15:0];
    assign byt   = rword[{a_addr[1:0], 3'b000} +: 8];

    always_comb begin
        err = a_we ? (a_wctr == 2'b11) : (a_octr > 3'd4);
`ifdef DM_ALIGN_CHECK_EN
        if (a_we)
            err = err | (a_wctr == 2'b00 && a_addr[1:0] != 2'b00) | (a_wctr == 2'b01 && a_addr[0]);
        else
            err = err | (a_octr == 3'b000 && a_addr[1:0] != 2'b00)
                      | ((a_octr == 3'b001 || a_octr == 3'b010) && a_addr[0]);
`endif
        case (a_octr)
            3'b000:  ldata = rword;
            3'b001:  ldata = {16'b0, half};
            3'b010:  ldata = {{16{half[15]}}, half};
            3'b011:  ldata = {24'b0, byt};
            3'b100:  ldata = {{24{byt[7]}}, byt};
            default: ldata = 32'b0;
        endcase
        resp_data = (a_we | err) ? 32'b0 : ldata;
        case (a_wctr)
            2'b00:   begin be = 4'hF;                        wd = a_wdata;               end
            2'b01:   begin be = a_addr[1] ? 4'hC : 4'h3;     wd = {2{a_wdata[15:0]}};    end
            2'b10:   begin be = 4'b0001 << a_addr[1:0];      wd = {4{a_wdata[7:0]}};     end
            default: begin be = 4'h0;                        wd = 32'b0;                 end
        endcase
        mem_wr = enter_resp & a_we & ~err & Rst;
    end

    // Storage is not reset; a store only lands on the edge that enters RESP.
    always_ff @(posedge Clk) begin
        if (mem_wr) begin
            for (int k = 0; k < 4; k++)
                if (be[k]) mem_q[idx][8*k +: 8] <= wd[8*k +: 8];
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            addr_q   <= '0;
            wdata_q  <= 32'b0;
            we_q     <= 1'b0;
            wctr_q   <= 2'b0;
            octr_q   <= 3'b0;
            ready_q  <= 1'b1;
            rvalid_q <= 1'b0;
            rdata_q  <= 32'b0;
            rerr_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (accept) begin
                    addr_q  <= Addr[AW-1:0];
                    wdata_q <= WriteData;
                    we_q    <= MemWrite;
                    wctr_q  <= MemWriteCtr;
                    octr_q  <= MemOutCtr;
                    ready_q <= 1'b0;
                    cnt_q   <= CNT_INIT;
                    state_q <= (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                    if (enter_resp) begin
                        rvalid_q <= 1'b1;
                        rdata_q  <= resp_data;
                        rerr_q   <= err;
                    end
                end
                S_WAIT: begin
                    if (enter_resp) begin
                        state_q  <= S_RESP;
                        rvalid_q <= 1'b1;
                        rdata_q  <= resp_data;
                        rerr_q   <= err;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_RESP: if (RespReady) begin
                    state_q  <= S_IDLE;
                    rvalid_q <= 1'b0;
                    ready_q  <= 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ReqReady  = ready_q;
    assign RespValid = rvalid_q;
    assign RespData  = rdata_q;
    assign RespErr   = rerr_q;
endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench for dm_responder: byte-level memory model, directed and random traffic.
module tb_dm_responder;
    localparam int WAIT = 2;

    logic        Clk, Rst, ReqValid, ReqReady, MemWrite, RespValid, RespReady, RespErr;
    logic [31:0] Addr, WriteData, RespData;
    logic [1:0]  MemWriteCtr;
    logic [2:0]  MemOutCtr;

    int n_chk = 0;
    int n_fail = 0;

    dm_responder #(.WAIT_CYCLES(WAIT), .DEPTH_LOG2(10)) dut (
        .Clk(Clk), .Rst(Rst), .ReqValid(ReqValid), .ReqReady(ReqReady), .Addr(Addr),
        .MemWrite(MemWrite), .MemWriteCtr(MemWriteCtr), .MemOutCtr(MemOutCtr),
        .WriteData(WriteData), .RespValid(RespValid), .RespReady(RespReady),
        .RespData(RespData), .RespErr(RespErr)
    );

    initial begin
        Clk = 0;
        forever #5 Clk = ~Clk;
    end

    // Model memory: first 64 bytes of the wrapped address space, little-endian bytes.
    logic [7:0]  mb [64];
    logic [32:0] exp_q [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic void model_eval(input logic [31:0] a, input logic w, input logic [1:0] wc,
                                       input logic [2:0] oc, input logic [31:0] wdv,
                                       output logic [31:0] d, output logic e);
        int sz, ea;
        bit sgn;
        logic [31:0] v;
        d = 0; e = 0; sgn = 0; sz = 4;
        if (w) begin
            if (wc == 2'd3) e = 1;
            else sz = (wc == 2'd0) ? 4 : (wc == 2'd1) ? 2 : 1;
        end else begin
            if (oc > 3'd4) e = 1;
            else begin
                sz  = (oc == 3'd0) ? 4 : (oc <= 3'd2) ? 2 : 1;
                sgn = (oc == 3'd2 || oc == 3'd4);
            end
        end
`ifdef DM_ALIGN_CHECK_EN
        if (!e && (int'(a[1:0]) % sz) != 0) e = 1;
`endif
        if (e) return;
        ea = int'(a[5:0]) & ~(sz - 1);
        if (w) begin
            for (int i = 0; i < sz; i++) mb[ea + i] = wdv[8*i +: 8];
        end else begin
            v = 0;
            for (int i = 0; i < sz; i++) v = v | (32'(mb[ea + i]) << (8 * i));
            if (sgn && sz < 4 && v[8*sz-1]) v = v | ~((32'h1 << (8 * sz)) - 1);
            d = v;
        end
    endfunction

    // Compare process: every cycle RespValid is up, outputs must equal the expected response.
    logic [32:0] cur;
    bit have = 0;
    always @(negedge Clk) begin
        if (!Rst || !RespValid) have = 0;
        else begin
            if (!have) begin
                if (exp_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL resp_unexpected: got RespValid=1 expected no response");
                end else begin
                    cur = exp_q.pop_front();
                    have = 1;
                end
            end
            if (have) begin
                chk("resp_data", RespData, cur[31:0]);
                chk("resp_err", {31'b0, RespErr}, {31'b0, cur[32]});
            end
        end
    end

    task automatic req(input logic [31:0] a, input logic w, input logic [1:0] wc, input logic [2:0] oc,
                       input logic [31:0] wdv, input int hold, output logic [31:0] rd, output logic re);
        logic [31:0] ed;
        logic ee;
        int lat;
        @(negedge Clk);
        Addr = a; MemWrite = w; MemWriteCtr = wc; MemOutCtr = oc; WriteData = wdv;
        ReqValid = 1; RespReady = 0;
        chk("req_ready_idle", {31'b0, ReqReady}, 32'd1);
        model_eval(a, w, wc, oc, wdv, ed, ee);
        exp_q.push_back({ee, ed});
        @(posedge Clk); #1;
        // Scramble inputs after acceptance; captured request must be unaffected.
        ReqValid = 1'($urandom_range(0, 1));
        Addr = $urandom; MemWrite = 1'($urandom); MemWriteCtr = 2'($urandom);
        MemOutCtr = 3'($urandom); WriteData = $urandom;
        lat = 0;
        do begin
            @(negedge Clk);
            lat++;
            if (!RespValid) chk("req_ready_busy", {31'b0, ReqReady}, 32'd0);
        end while (!RespValid && lat < 40);
        chk("latency", lat, WAIT + 1);
        rd = RespData; re = RespErr;
        for (int h = 0; h < hold; h++) begin
            chk("hold_req_ready", {31'b0, ReqReady}, 32'd0);
            chk("hold_valid", {31'b0, RespValid}, 32'd1);
            chk("hold_data", RespData, rd);
            ReqValid = 1;
            @(negedge Clk);
        end
        ReqValid = 0;
        RespReady = 1;
        @(negedge Clk);
        RespReady = 0;
        chk("post_valid", {31'b0, RespValid}, 32'd0);
        chk("post_ready", {31'b0, ReqReady}, 32'd1);
    endtask

    task automatic lit(input string nm, input logic [31:0] a, input logic w, input logic [1:0] wc,
                       input logic [2:0] oc, input logic [31:0] wdv, input logic [31:0] ed, input logic ee);
        logic [31:0] rd;
        logic re;
        req(a, w, wc, oc, wdv, 0, rd, re);
        chk({nm, "_data"}, rd, ed);
        chk({nm, "_err"}, {31'b0, re}, {31'b0, ee});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, a;
        logic re;
        for (int i = 0; i < 64; i++) mb[i] = 8'h00;
        Rst = 0; ReqValid = 0; RespReady = 0; Addr = 0; MemWrite = 0;
        MemWriteCtr = 0; MemOutCtr = 0; WriteData = 0;
        #23;
        chk("rst_valid", {31'b0, RespValid}, 32'd0);
        chk("rst_data", RespData, 32'd0);
        chk("rst_err", {31'b0, RespErr}, 32'd0);
        @(negedge Clk); Rst = 1;
        @(negedge Clk);
        chk("rst_ready", {31'b0, ReqReady}, 32'd1);

        for (int i = 0; i < 16; i++) req(32'(i * 4), 1, 2'b00, 3'b000, 32'h0, 0, rd, re);

        lit("sw10",  32'h10, 1, 2'b00, 3'b000, 32'h12345678, 32'h0, 0);
        lit("lw10",  32'h10, 0, 2'b00, 3'b000, 32'h0, 32'h12345678, 0);
        lit("sb11",  32'h11, 1, 2'b10, 3'b000, 32'hFFFFFFAB, 32'h0, 0);
        lit("lb11",  32'h11, 0, 2'b00, 3'b100, 32'h0, 32'hFFFFFFAB, 0);
        lit("lbu11", 32'h11, 0, 2'b00, 3'b011, 32'h0, 32'h000000AB, 0);
        lit("lw10b", 32'h10, 0, 2'b00, 3'b000, 32'h0, 32'h1234AB78, 0);
        lit("sh22",  32'h22, 1, 2'b01, 3'b000, 32'h55558001, 32'h0, 0);
        lit("lh22",  32'h22, 0, 2'b00, 3'b010, 32'h0, 32'hFFFF8001, 0);
        lit("lhu22", 32'h22, 0, 2'b00, 3'b001, 32'h0, 32'h00008001, 0);
        lit("lw20",  32'h20, 0, 2'b00, 3'b000, 32'h0, 32'h80010000, 0);

        req(32'h10, 0, 2'b00, 3'b000, 32'h0, 5, rd, re);
        chk("bp_data", rd, 32'h1234AB78);

`ifdef DM_ALIGN_CHECK_EN
        lit("lw13", 32'h13, 0, 2'b00, 3'b000, 32'h0, 32'h0, 1);
`else
        lit("lw13", 32'h13, 0, 2'b00, 3'b000, 32'h0, 32'h1234AB78, 0);
`endif
        lit("sw_rsv", 32'h10, 1, 2'b11, 3'b000, 32'hCAFEF00D, 32'h0, 1);
        lit("lw10c",  32'h10, 0, 2'b00, 3'b000, 32'h0, 32'h1234AB78, 0);
        lit("sw_wrap", 32'hFFFFF018, 1, 2'b00, 3'b000, 32'h5555AAAA, 32'h0, 0);
        lit("lw_wrap", 32'h18, 0, 2'b00, 3'b000, 32'h0, 32'h5555AAAA, 0);

        // Store aborted by reset during WAIT must leave memory untouched.
        @(negedge Clk);
        Addr = 32'h30; MemWrite = 1; MemWriteCtr = 2'b00; WriteData = 32'hDEADBEEF; ReqValid = 1;
        @(posedge Clk); #1;
        ReqValid = 0;
        @(negedge Clk);
        Rst = 0;
        #2;
        chk("abort_valid", {31'b0, RespValid}, 32'd0);
        chk("abort_err", {31'b0, RespErr}, 32'd0);
        @(negedge Clk); @(negedge Clk);
        Rst = 1;
        @(negedge Clk);
        chk("abort_ready", {31'b0, ReqReady}, 32'd1);
        lit("lw30", 32'h30, 0, 2'b00, 3'b000, 32'h0, 32'h0, 0);
        lit("lw_rsv", 32'h30, 0, 2'b00, 3'b111, 32'h0, 32'h0, 1);

        for (int t = 0; t < 300; t++) begin
            a = ($urandom & 32'hFFFFF000) | 32'($urandom_range(0, 63));
            req(a, 1'($urandom), 2'($urandom), ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7))
                                                                        : 3'($urandom_range(0, 4)),
                $urandom, $urandom_range(0, 3), rd, re);
        end

        @(negedge Clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
